// File: rtl/thee_frac_div_pkg.sv
// rtl/thee_frac_div_pkg.sv - shared types and constants for the fractional-N clock divider
package thee_frac_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Signed width holding the MASH output: 0..1, -1..2, -3..4 for orders 1..3
    function automatic int delta_width(input int order);
        case (order)
            1:       return 2;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

endpackage

// File: rtl/thee_mash_sdm.sv
// rtl/thee_mash_sdm.sv - MASH 1-1-1 sigma-delta modulator, order 1..3, advanced on step
// Optional LSB dither enabled by THEE_FRAC_CLK_DIV_DITHER_EN.
module thee_mash_sdm
    import thee_frac_div_pkg::*;
#(
    parameter int FRAC_WIDTH = 4,
    parameter int ORDER      = 1,
    parameter int DELTA_W    = delta_width(ORDER)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      step,
    input  logic [FRAC_WIDTH-1:0]     frac,
    output logic signed [DELTA_W-1:0] delta
);

    if (ORDER < 1 || ORDER > 3) begin : g_bad_order
        $error("thee_mash_sdm: ORDER must be 1, 2 or 3");
    end

`ifdef THEE_FRAC_CLK_DIV_DITHER_EN
    localparam int A1W = FRAC_WIDTH + 1;
    logic [15:0] lfsr;
    logic [A1W-1:0] in1;
    assign in1 = {frac, lfsr[0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= LFSR_SEED;
        end else if (step) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end
`else
    localparam int A1W = FRAC_WIDTH;
    logic [A1W-1:0] in1;
    assign in1 = frac;
`endif

    logic [A1W-1:0]        acc1, acc1_n;
    logic [FRAC_WIDTH-1:0] acc2, acc2_n, acc3, acc3_n;
    logic                  c1, c2, c3;
    logic                  c2_d, c3_d, c3_dd;
    logic signed [DELTA_W-1:0] t1, t2, t3;

    // Carries come from the post-step accumulator values so the load that steps uses them.
    assign {c1, acc1_n} = {1'b0, acc1} + {1'b0, in1};
    assign {c2, acc2_n} = {1'b0, acc2} + {1'b0, acc1_n[A1W-1 -: FRAC_WIDTH]};
    assign {c3, acc3_n} = {1'b0, acc3} + {1'b0, acc2_n};

    assign t1 = DELTA_W'(c1);
    assign t2 = DELTA_W'(c2) - DELTA_W'(c2_d);
    assign t3 = DELTA_W'(c3) - DELTA_W'({c3_d, 1'b0}) + DELTA_W'(c3_dd);

    always_comb begin
        delta = t1;
        case (ORDER)
            1:       delta = t1;
            2:       delta = t1 + t2;
            default: delta = t1 + t2 + t3;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc1  <= '0;
            acc2  <= '0;
            acc3  <= '0;
            c2_d  <= 1'b0;
            c3_d  <= 1'b0;
            c3_dd <= 1'b0;
        end else if (step) begin
            acc1  <= acc1_n;
            acc2  <= acc2_n;
            acc3  <= acc3_n;
            c2_d  <= c2;
            c3_d  <= c3;
            c3_dd <= c3_d;
        end
    end

endmodule

// File: rtl/thee_frac_clk_div.sv
// rtl/thee_frac_clk_div.sv - fractional-N clock divider: FSM, period counter and clock shaping
module thee_frac_clk_div
    import thee_frac_div_pkg::*;
#(
    parameter int INT_WIDTH  = 6,
    parameter int FRAC_WIDTH = 4,
    parameter int ORDER      = 1,
    parameter int MIN_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [INT_WIDTH-1:0]  int_div,
    input  logic [FRAC_WIDTH-1:0] frac_div,
    output logic                  clkout,
    output logic                  div_pulse,
    output logic [INT_WIDTH+2:0]  cur_div,
    output logic                  sat
);

    localparam int DW = delta_width(ORDER);
    localparam int CW = INT_WIDTH + 3;

    fsm_state_e           state;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_dec;
    logic [CW-1:0]        thr;
    logic                 load;
    logic signed [DW-1:0] delta;
    logic signed [CW:0]   n_raw;
    logic                 clamp;
    logic [CW-1:0]        n_load;

    assign load = en && (state == IDLE || count == '0);

    thee_mash_sdm #(
        .FRAC_WIDTH (FRAC_WIDTH),
        .ORDER      (ORDER),
        .DELTA_W    (DW)
    ) u_sdm (
        .clk   (clk),
        .rstn  (rstn),
        .step  (load),
        .frac  (frac_div),
        .delta (delta)
    );

    assign n_raw  = $signed({{(CW + 1 - INT_WIDTH){1'b0}}, int_div})
                  + $signed({{(CW + 1 - DW){delta[DW-1]}}, delta});
    assign clamp  = n_raw < $signed((CW + 1)'(MIN_DIV));
    assign n_load = clamp ? CW'(MIN_DIV) : n_raw[CW-1:0];

    // High while the counter is above this point: floor(N/2) high, ceil(N/2) low.
    assign thr       = cur_div - CW'(1) - (cur_div >> 1);
    assign count_dec = count - CW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            count     <= '0;
            cur_div   <= '0;
            clkout    <= 1'b0;
            div_pulse <= 1'b0;
            sat       <= 1'b0;
        end else begin
            div_pulse <= 1'b0;
            if (load) begin
                state     <= RUN;
                cur_div   <= n_load;
                count     <= n_load - CW'(1);
                div_pulse <= 1'b1;
                clkout    <= 1'b1;
                if (clamp) begin
                    sat <= 1'b1;
                end
            end else if (state == RUN && count != '0) begin
                count  <= count_dec;
                clkout <= count_dec > thr;
            end else begin
                state  <= IDLE;
                clkout <= 1'b0;
            end
        end
    end

endmodule
